keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/keypad_scanner_sync2.sv | 23 ++
 rtl/keypad_scanner.sv | 156 +++++++++++++++
 tb/tb_keypad_scanner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DB_PRESS,
        HELD,
        DB_RELEASE
    } state_t;

    localparam logic [3:0] ROW0   = 4'b1110;
    localparam logic [3:0] ROW1   = 4'b1101;
    localparam logic [3:0] ROW2   = 4'b1011;
    localparam logic [3:0] ROW3   = 4'b0111;
    localparam logic [3:0] NO_KEY = 4'b1111;

    function automatic logic one_low(input logic [3:0] v);
        return (v == ROW0) || (v == ROW1) || (v == ROW2) || (v == ROW3);
    endfunction

    function automatic logic [3:0] next_row(input logic [3:0] r);
        return {r[2:0], r[3]};
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the raw column inputs; resets to idle.
module sync2
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= NO_KEY;
            q    <= NO_KEY;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-scanning keypad controller with press/release debounce.
// Define KEYPAD_REPEAT_EN to enable auto-repeat pulses while a key is held.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int REPEAT_CYCLES   = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_valid,
    output logic       key_pulse
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST  = BW'(DEBOUNCE_CYCLES - 1);

    state_t        state, state_n;
    logic [3:0]    scol;
    logic [3:0]    row_n, key_row_n, key_col_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [BW-1:0] db_cnt, db_n;
    logic          pulse_n;
    logic          rep_hit;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col),
        .q     (scol)
    );

    assign key_valid = (state == HELD) || (state == DB_RELEASE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            row       <= ROW0;
            key_row   <= NO_KEY;
            key_col   <= NO_KEY;
            div_cnt   <= '0;
            db_cnt    <= '0;
            key_pulse <= 1'b0;
        end else begin
            state     <= state_n;
            row       <= row_n;
            key_row   <= key_row_n;
            key_col   <= key_col_n;
            div_cnt   <= div_n;
            db_cnt    <= db_n;
            key_pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n   = state;
        row_n     = row;
        key_row_n = key_row;
        key_col_n = key_col;
        div_n     = div_cnt;
        db_n      = db_cnt;
        pulse_n   = 1'b0;
        unique case (state)
            SCAN: begin
                if (div_cnt != DIV_LAST) begin
                    div_n = div_cnt + 1'b1;
                end else begin
                    div_n = '0;
                    if (one_low(scol)) begin
                        state_n   = DB_PRESS;
                        key_row_n = row;
                        key_col_n = scol;
                        db_n      = '0;
                    end else begin
                        row_n = next_row(row);
                    end
                end
            end
            DB_PRESS: begin
                if (scol != key_col) begin
                    state_n   = SCAN;
                    row_n     = next_row(row);
                    key_row_n = NO_KEY;
                    key_col_n = NO_KEY;
                    div_n     = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_n = HELD;
                    pulse_n = 1'b1;
                end else begin
                    db_n = db_cnt + 1'b1;
                end
            end
            HELD: begin
                // a second key on another row cannot disturb the frozen row
                if (scol == NO_KEY) begin
                    state_n = DB_RELEASE;
                    db_n    = '0;
                end else begin
                    pulse_n = rep_hit;
                end
            end
            DB_RELEASE: begin
                if (scol != NO_KEY) begin
                    state_n = HELD;
                end else if (db_cnt == DB_LAST) begin
                    state_n   = SCAN;
                    row_n     = ROW0;
                    key_row_n = NO_KEY;
                    key_col_n = NO_KEY;
                    div_n     = '0;
                end else begin
                    db_n = db_cnt + 1'b1;
                end
            end
            default: state_n = SCAN;
        endcase
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt, rep_n;

    assign rep_hit = (rep_cnt == REP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_n;
        end
    end

    // holds its value through DB_RELEASE so a bounce does not restart it
    always_comb begin
        rep_n = rep_cnt;
        if (state == DB_PRESS && state_n == HELD) begin
            rep_n = '0;
        end else if (state == HELD && state_n == HELD) begin
            rep_n = rep_hit ? '0 : rep_cnt + 1'b1;
        end
    end
`else
    // auto-repeat compiled out
    assign rep_hit = (REPEAT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner.
module tb_keypad_scanner;

    localparam int SD  = 4;
    localparam int DB  = 8;
    localparam int REP = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       col;
    logic [3:0]       row, key_row, key_col;
    logic             key_valid, key_pulse;
    logic [3:0][3:0]  pressed = '0;
    int               cyc = 0;
    int               checks = 0;
    int               failures = 0;

    typedef struct {
        int         at;
        logic [3:0] kr;
        logic [3:0] kc;
    } exp_t;

    exp_t sb[$];

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_valid (key_valid),
        .key_pulse (key_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // matrix model: a closed switch pulls its column low when its row is driven
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r][c] && !row[r]) col[c] = 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] pat(input int i);
        logic [3:0] one;
        one = 4'b0001 << i;
        return ~one;
    endfunction

    always @(negedge clk) begin
        if (!reset && key_pulse) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e.at));
                chk("pulse_key_row", 32'(key_row), 32'(e.kr));
                chk("pulse_key_col", 32'(key_col), 32'(e.kc));
                chk("pulse_valid", 32'(key_valid), 32'd1);
            end
        end
    end

    task automatic run_to(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic do_reset(input int r, input int c);
        @(negedge clk);
        reset = 1'b1;
        pressed = '0;
        #1;
        chk("rst_row", 32'(row), 32'(pat(0)));
        chk("rst_key_row", 32'(key_row), 32'hF);
        chk("rst_key_col", 32'(key_col), 32'hF);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_pulse", 32'(key_pulse), 32'd0);
        repeat (2) @(negedge clk);
        if (r >= 0) pressed[r][c] = 1'b1;
        reset = 1'b0;
    endtask

    // key pressed from reset release is captured at the first sample of its row
    function automatic int accept_at(input int r);
        return SD * (r + 1) + DB;
    endfunction

    task automatic push_key(input int r, input int c, input int rel);
        exp_t e;
        e.at = accept_at(r);
        e.kr = pat(r);
        e.kc = pat(c);
        sb.push_back(e);
`ifdef KEYPAD_REPEAT_EN
        for (int k = 1; accept_at(r) + REP * k <= rel + 2; k++) begin
            e.at = accept_at(r) + REP * k;
            sb.push_back(e);
        end
`else
        if (rel < 0) sb.push_back(e);
`endif
    endtask

    task automatic press_release(input int r, input int c, input int hold);
        int p, rel;
        do_reset(r, c);
        p = accept_at(r);
        rel = p + hold;
        push_key(r, c, rel);
        run_to(p - 1);
        chk("valid_before_accept", 32'(key_valid), 32'd0);
        run_to(p + 1);
        chk("held_valid", 32'(key_valid), 32'd1);
        chk("held_key_row", 32'(key_row), 32'(pat(r)));
        chk("held_key_col", 32'(key_col), 32'(pat(c)));
        run_to(rel);
        pressed = '0;
        run_to(rel + 10);
        chk("valid_in_release_db", 32'(key_valid), 32'd1);
        run_to(rel + 11);
        chk("valid_after_release", 32'(key_valid), 32'd0);
        chk("idle_key_row", 32'(key_row), 32'hF);
        chk("idle_key_col", 32'(key_col), 32'hF);
        chk("resume_row0", 32'(row), 32'(pat(0)));
        run_to(rel + 20);
        chk("missing_pulse", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        // idle scan
        do_reset(-1, 0);
        for (int e = 0; e <= 40; e++) begin
            run_to(e);
            chk("idle_row", 32'(row), 32'(pat((e / SD) % 4)));
        end
        chk("idle_valid", 32'(key_valid), 32'd0);

        // key 6 held 100 cycles after accept
        press_release(1, 2, 100);

        // random keys and hold times
        for (int i = 0; i < 5; i++)
            press_release($urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(12, 70));

        // contact bouncing every 3 cycles on key 6
        do_reset(-1, 0);
        for (int e = 0; e <= 80; e++) begin
            run_to(e);
            pressed[1][2] = (e >= 4) && (((e - 4) / 3) % 2 == 0);
            if (e == 8) chk("bounce_capture_row", 32'(key_row), 32'(pat(1)));
            if (e == 10) begin
                chk("bounce_next_row", 32'(row), 32'(pat(2)));
                chk("bounce_key_row", 32'(key_row), 32'hF);
            end
            if (e == 12) chk("bounce_row_dwell", 32'(row), 32'(pat(2)));
        end
        pressed = '0;
        chk("bounce_valid", 32'(key_valid), 32'd0);
        chk("bounce_no_pulse", 32'(sb.size()), 32'd0);

        // key 5 held, key 9 added and removed while held
        do_reset(1, 1);
        push_key(1, 1, 70);
        run_to(30);
        pressed[2][2] = 1'b1;
        run_to(40);
        chk("two_key_col", 32'(key_col), 32'(pat(1)));
        chk("two_key_row", 32'(key_row), 32'(pat(1)));
        run_to(50);
        pressed[2][2] = 1'b0;
        run_to(60);
        chk("two_key_valid", 32'(key_valid), 32'd1);
        run_to(70);
        pressed[1][1] = 1'b0;
        run_to(80);
        chk("two_key_release_db", 32'(key_valid), 32'd1);
        run_to(81);
        chk("two_key_idle", 32'(key_valid), 32'd0);
        run_to(90);
        chk("two_key_pulses", 32'(sb.size()), 32'd0);

        // reset while debouncing a press
        do_reset(1, 2);
        run_to(11);
        do_reset(-1, 0);
        run_to(40);
        chk("rst_db_no_pulse", 32'(sb.size()), 32'd0);

        // reset while held
        do_reset(3, 0);
        push_key(3, 0, 1000);
        run_to(26);
        chk("pre_rst_key_row", 32'(key_row), 32'(pat(3)));
        chk("pre_rst_key_col", 32'(key_col), 32'(pat(0)));
        run_to(27);
        sb.delete();
        push_key(3, 0, 27);
        sb.delete();
        do_reset(-1, 0);
        run_to(60);
        chk("rst_held_no_pulse", 32'(sb.size()), 32'd0);
        chk("rst_held_valid", 32'(key_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
